// File: rtl/tri_setup_walker.sv
// -----------------------------------------------------------------------------
// tri_setup_walker
//
// Front end of the raster pipe. Accepts one screen-space triangle per
// tri_valid/tri_ready handshake and rotates it so that the topmost vertex
// (smallest y, lowest index on a tie) becomes A, with winding preserved. It
// then publishes the per-triangle setup bus and walks the screen-clipped
// bounding box row-major, one pixel per accepted pix_valid/pix_ready beat.
// The setup bus is held stable for the whole walk so that a combinational
// barycentric stage downstream can consume it together with (x, y).
//
// Timeline (cycle 0 = handshake):
//   cycle 1  SORT   pick A, derive B/C in cyclic order
//   cycle 2  SETUP  edge vectors, range check, clipped bbox, setup bus
//   cycle 3  WALK   first pixel at (xmin, ymin)
//   after the final accepted pixel: DONE (tri_done pulse), then IDLE.
//   Rejected triangles go SETUP -> DROP (tri_drop pulse) -> IDLE.
//
// Optional feature, macro TRI_CULL_EN:
//   When defined, an extra CULL cycle after SETUP evaluates the doubled
//   signed area abx*acy - aby*acx; zero-area (degenerate) triangles are
//   dropped and the first pixel moves to cycle 4. When undefined there is no
//   area logic and degenerate triangles are walked like any other.
//
// Parameters:
//   SCREEN_W   visible width,  walk x clipped to [0, SCREEN_W-1]
//   SCREEN_H   visible height, walk y clipped to [0, SCREEN_H-1] (<= 128)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tri_valid/tri_ready   triangle handshake (ready only in IDLE)
//   v0x..v2x [8:0]        vertex x, unsigned
//   v0y..v2y [6:0]        vertex y, unsigned
//   v0z..v2z [6:0]        vertex depth weight, unsigned
//   ax [8:0], ay [6:0]    top vertex position
//   az, bz, cz [6:0]      depth weights of A, B, C
//   abx, acx [7:0]        B-A and C-A in x, two's complement
//   aby, acy [7:0]        B-A and C-A in y, never negative
//   pix_valid/pix_ready   pixel handshake
//   x, y [9:0]            pixel coordinate, zero-extended
//   pix_last              marks the final pixel of the walk
//   tri_done              one-cycle pulse after the last pixel is accepted
//   tri_drop              one-cycle pulse when a triangle is rejected
// -----------------------------------------------------------------------------
module tri_setup_walker #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tri_valid,
    output logic       tri_ready,
    input  logic [8:0] v0x,
    input  logic [8:0] v1x,
    input  logic [8:0] v2x,
    input  logic [6:0] v0y,
    input  logic [6:0] v1y,
    input  logic [6:0] v2y,
    input  logic [6:0] v0z,
    input  logic [6:0] v1z,
    input  logic [6:0] v2z,
    output logic [8:0] ax,
    output logic [6:0] ay,
    output logic [6:0] az,
    output logic [6:0] bz,
    output logic [6:0] cz,
    output logic [7:0] abx,
    output logic [7:0] acx,
    output logic [7:0] aby,
    output logic [7:0] acy,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_last,
    output logic       tri_done,
    output logic       tri_drop
);

    localparam logic [9:0] XLIM = 10'(SCREEN_W);
    localparam logic [9:0] YLIM = 10'(SCREEN_H);
    localparam logic [9:0] XMAX_CLIP = 10'(SCREEN_W - 1);
    localparam logic [9:0] YMAX_CLIP = 10'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SORT,
        S_SETUP,
        S_CULL,
        S_WALK,
        S_DONE,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Raw vertices, captured at the handshake only.
    logic [8:0] r_v0x, r_v1x, r_v2x;
    logic [6:0] r_v0y, r_v1y, r_v2y;
    logic [6:0] r_v0z, r_v1z, r_v2z;

    // Rotated vertices (A topmost), valid from SETUP onward.
    logic [8:0] r_sax, r_sbx, r_scx;
    logic [6:0] r_say, r_sby, r_scy;
    logic [6:0] r_saz, r_sbz, r_scz;

    // Setup bus registers.
    logic [8:0] r_ax;
    logic [6:0] r_ay, r_az, r_bz, r_cz;
    logic [7:0] r_abx, r_acx, r_aby, r_acy;

    // Clipped bounding box and walk position.
    logic [9:0] r_xmin, r_xmax, r_ymax;
    logic [9:0] r_x, r_y;

    // Rotation selection.
    logic [8:0] w_sax, w_sbx, w_scx;
    logic [6:0] w_say, w_sby, w_scy;
    logic [6:0] w_saz, w_sbz, w_scz;

    // Setup arithmetic.
    logic signed [9:0] w_abx, w_acx;
    logic [6:0] w_aby, w_acy;
    logic       w_range_bad;
    logic [8:0] w_xmin9, w_xmax9, w_ymin9, w_ymax9;
    logic [9:0] w_xmin, w_xmax_c, w_ymin, w_ymax_c;
    logic       w_empty;

    logic       w_last;
    logic       w_beat;

    function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // -------------------------------------------------------------------------
    // Rotation: A is the vertex with the smallest y, ties resolved toward the
    // lowest index. B and C follow A in cyclic order so winding is unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // through the block leaves it unassigned, which would infer a latch.
        w_sax = r_v0x; w_say = r_v0y; w_saz = r_v0z;
        w_sbx = r_v1x; w_sby = r_v1y; w_sbz = r_v1z;
        w_scx = r_v2x; w_scy = r_v2y; w_scz = r_v2z;
        if ((r_v0y <= r_v1y) && (r_v0y <= r_v2y)) begin
            // A = V0, defaults already hold B = V1, C = V2.
        end else if (r_v1y <= r_v2y) begin
            w_sax = r_v1x; w_say = r_v1y; w_saz = r_v1z;
            w_sbx = r_v2x; w_sby = r_v2y; w_sbz = r_v2z;
            w_scx = r_v0x; w_scy = r_v0y; w_scz = r_v0z;
        end else begin
            w_sax = r_v2x; w_say = r_v2y; w_saz = r_v2z;
            w_sbx = r_v0x; w_sby = r_v0y; w_sbz = r_v0z;
            w_scx = r_v1x; w_scy = r_v1y; w_scz = r_v1z;
        end
    end

    // -------------------------------------------------------------------------
    // Setup arithmetic on the rotated vertices. Edge x deltas are formed in
    // 10-bit signed so any pair of 9-bit coordinates fits before the range
    // check; y deltas cannot go negative because A has the minimum y.
    // -------------------------------------------------------------------------
    assign w_abx = $signed({1'b0, r_sbx}) - $signed({1'b0, r_sax});
    assign w_acx = $signed({1'b0, r_scx}) - $signed({1'b0, r_sax});
    assign w_aby = r_sby - r_say;
    assign w_acy = r_scy - r_say;

    assign w_range_bad = (w_abx < -10'sd128) || (w_abx > 10'sd127) ||
                         (w_acx < -10'sd128) || (w_acx > 10'sd127);

    assign w_xmin9 = min3(r_sax, r_sbx, r_scx);
    assign w_xmax9 = max3(r_sax, r_sbx, r_scx);
    assign w_ymin9 = min3({2'b0, r_say}, {2'b0, r_sby}, {2'b0, r_scy});
    assign w_ymax9 = max3({2'b0, r_say}, {2'b0, r_sby}, {2'b0, r_scy});

    // Coordinates are unsigned, so only the high side ever needs clipping.
    assign w_xmin   = {1'b0, w_xmin9};
    assign w_ymin   = {1'b0, w_ymin9};
    assign w_xmax_c = ({1'b0, w_xmax9} > XMAX_CLIP) ? XMAX_CLIP : {1'b0, w_xmax9};
    assign w_ymax_c = ({1'b0, w_ymax9} > YMAX_CLIP) ? YMAX_CLIP : {1'b0, w_ymax9};
    assign w_empty  = (w_xmin >= XLIM) || (w_ymin >= YLIM);

`ifdef TRI_CULL_EN
    // Doubled signed area from the registered setup bus; every factor is
    // widened to the 17-bit result before multiplying.
    logic signed [16:0] w_abx_e, w_acx_e, w_aby_e, w_acy_e;
    logic signed [16:0] w_area;

    assign w_abx_e = 17'($signed(r_abx));
    assign w_acx_e = 17'($signed(r_acx));
    assign w_aby_e = $signed({9'b0, r_aby});
    assign w_acy_e = $signed({9'b0, r_acy});
    assign w_area  = (w_abx_e * w_acy_e) - (w_aby_e * w_acx_e);
`endif

    assign w_last = (r_x == r_xmax) && (r_y == r_ymax);
    assign w_beat = (r_state == S_WALK) && pix_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (tri_valid) w_state_nxt = S_SORT;
            S_SORT:  w_state_nxt = S_SETUP;
            S_SETUP: begin
                if (w_range_bad || w_empty) begin
                    w_state_nxt = S_DROP;
                end else begin
`ifdef TRI_CULL_EN
                    w_state_nxt = S_CULL;
`else
                    w_state_nxt = S_WALK;
`endif
                end
            end
`ifdef TRI_CULL_EN
            S_CULL:  w_state_nxt = (w_area == 17'sd0) ? S_DROP : S_WALK;
`else
            S_CULL:  w_state_nxt = S_IDLE;
`endif
            S_WALK:  if (pix_ready && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            S_DROP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        tri_ready = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tri_done  = 1'b0;
        tri_drop  = 1'b0;
        unique case (r_state)
            S_IDLE: tri_ready = 1'b1;
            S_WALK: begin
                pix_valid = 1'b1;
                pix_last  = w_last;
            end
            S_DONE: tri_done = 1'b1;
            S_DROP: tri_drop = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0x <= '0; r_v1x <= '0; r_v2x <= '0;
            r_v0y <= '0; r_v1y <= '0; r_v2y <= '0;
            r_v0z <= '0; r_v1z <= '0; r_v2z <= '0;
            r_sax <= '0; r_sbx <= '0; r_scx <= '0;
            r_say <= '0; r_sby <= '0; r_scy <= '0;
            r_saz <= '0; r_sbz <= '0; r_scz <= '0;
            r_ax  <= '0; r_ay  <= '0;
            r_az  <= '0; r_bz  <= '0; r_cz  <= '0;
            r_abx <= '0; r_acx <= '0; r_aby <= '0; r_acy <= '0;
            r_xmin <= '0; r_xmax <= '0; r_ymax <= '0;
            r_x    <= '0; r_y    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here samples the values from before this clock edge.
            if ((r_state == S_IDLE) && tri_valid) begin
                r_v0x <= v0x; r_v1x <= v1x; r_v2x <= v2x;
                r_v0y <= v0y; r_v1y <= v1y; r_v2y <= v2y;
                r_v0z <= v0z; r_v1z <= v1z; r_v2z <= v2z;
            end

            if (r_state == S_SORT) begin
                r_sax <= w_sax; r_sbx <= w_sbx; r_scx <= w_scx;
                r_say <= w_say; r_sby <= w_sby; r_scy <= w_scy;
                r_saz <= w_saz; r_sbz <= w_sbz; r_scz <= w_scz;
            end

            // Setup bus and bbox freeze here until the next triangle.
            if (r_state == S_SETUP) begin
                r_ax   <= r_sax;
                r_ay   <= r_say;
                r_az   <= r_saz;
                r_bz   <= r_sbz;
                r_cz   <= r_scz;
                r_abx  <= w_abx[7:0];
                r_acx  <= w_acx[7:0];
                r_aby  <= {1'b0, w_aby};
                r_acy  <= {1'b0, w_acy};
                r_xmin <= w_xmin;
                r_xmax <= w_xmax_c;
                r_ymax <= w_ymax_c;
                r_x    <= w_xmin;
                r_y    <= w_ymin;
            end

            // Row-major advance, only on an accepted beat.
            if (w_beat && !w_last) begin
                if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    r_y <= r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
        end
    end

    assign ax  = r_ax;
    assign ay  = r_ay;
    assign az  = r_az;
    assign bz  = r_bz;
    assign cz  = r_cz;
    assign abx = r_abx;
    assign acx = r_acx;
    assign aby = r_aby;
    assign acy = r_acy;
    assign x   = r_x;
    assign y   = r_y;

endmodule

// File: tb/tb_tri_setup_walker.sv
// -----------------------------------------------------------------------------
// tb_tri_setup_walker
//
// Table-driven bench: each record holds three vertices plus the expected setup
// bus, bounding box and pixel count (or an expected drop). Each record is run
// as a full triangle; the walk is checked against a row-major walk of the
// expected bbox. Hand sequences cover reset, backpressure and reset mid-walk.
// -----------------------------------------------------------------------------
module tb_tri_setup_walker;

    logic       clk;
    logic       rst_n;
    logic       tri_valid;
    logic       tri_ready;
    logic [8:0] v0x, v1x, v2x;
    logic [6:0] v0y, v1y, v2y;
    logic [6:0] v0z, v1z, v2z;
    logic [8:0] ax;
    logic [6:0] ay, az, bz, cz;
    logic [7:0] abx, acx, aby, acy;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] x, y;
    logic       pix_last;
    logic       tri_done;
    logic       tri_drop;

    int n_tests;
    int n_fail;

`ifdef TRI_CULL_EN
    localparam int LAT = 4;
    localparam int COLLINEAR_DROP = 1;
`else
    localparam int LAT = 3;
    localparam int COLLINEAR_DROP = 0;
`endif

    tri_setup_walker #(.SCREEN_W(320), .SCREEN_H(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .v0x       (v0x),
        .v1x       (v1x),
        .v2x       (v2x),
        .v0y       (v0y),
        .v1y       (v1y),
        .v2y       (v2y),
        .v0z       (v0z),
        .v1z       (v1z),
        .v2z       (v2z),
        .ax        (ax),
        .ay        (ay),
        .az        (az),
        .bz        (bz),
        .cz        (cz),
        .abx       (abx),
        .acx       (acx),
        .aby       (aby),
        .acy       (acy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .x         (x),
        .y         (y),
        .pix_last  (pix_last),
        .tri_done  (tri_done),
        .tri_drop  (tri_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int v0x, v0y, v0z, v1x, v1y, v1z, v2x, v2y, v2z;
        int drop;
        int ax, ay, abx, aby, acx, acy;
        int az, bz, cz;
        int xmin, ymin, xmax, ymax;
        int npix;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic any_set;
        any_set = |{ax, ay, az, bz, cz, abx, acx, aby, acy, x, y,
                    pix_valid, pix_last, tri_done, tri_drop};
        check({tag, "_outputs_zero"}, any_set, 0);
        check({tag, "_tri_ready"}, tri_ready, 1);
    endtask

    // Run one triangle from the table. bp enables random pix_ready stalls;
    // abort_after > 0 pulls reset after that many accepted pixels.
    task automatic run_tri(input int idx, input bit bp, input int abort_after);
        vec_t t;
        int   cyc, npix, ex, ey, guard;
        bit   order_ok, last_ok, fin, rdy;
        t = vecs[idx];

        @(negedge clk);
        check($sformatf("v%0d_ready_idle", idx), tri_ready, 1);
        tri_valid = 1'b1;
        v0x = 9'(t.v0x); v0y = 7'(t.v0y); v0z = 7'(t.v0z);
        v1x = 9'(t.v1x); v1y = 7'(t.v1y); v1z = 7'(t.v1z);
        v2x = 9'(t.v2x); v2y = 7'(t.v2y); v2z = 7'(t.v2z);
        @(negedge clk);
        // Scramble vertex inputs: only the handshake values may matter.
        tri_valid = 1'b0;
        v0x = 9'($urandom); v1x = 9'($urandom); v2x = 9'($urandom);
        v0y = 7'($urandom); v1y = 7'($urandom); v2y = 7'($urandom);
        v0z = 7'($urandom); v1z = 7'($urandom); v2z = 7'($urandom);

        cyc = 1;
        while (cyc < 12 && !pix_valid && !tri_drop) begin
            @(negedge clk);
            cyc++;
        end

        if (t.drop != 0) begin
            check($sformatf("v%0d_drop_pulse", idx), tri_drop, 1);
            check($sformatf("v%0d_drop_no_pixel", idx), pix_valid, 0);
            @(negedge clk);
            check($sformatf("v%0d_drop_one_cycle", idx), tri_drop, 0);
            check($sformatf("v%0d_drop_ready_after", idx), tri_ready, 1);
            return;
        end

        check($sformatf("v%0d_first_pixel_cycle", idx), cyc, LAT);
        check($sformatf("v%0d_ax", idx), ax, t.ax);
        check($sformatf("v%0d_ay", idx), ay, t.ay);
        check($sformatf("v%0d_abx", idx), $signed(abx), t.abx);
        check($sformatf("v%0d_aby", idx), aby, t.aby);
        check($sformatf("v%0d_acx", idx), $signed(acx), t.acx);
        check($sformatf("v%0d_acy", idx), acy, t.acy);
        check($sformatf("v%0d_az", idx), az, t.az);
        check($sformatf("v%0d_bz", idx), bz, t.bz);
        check($sformatf("v%0d_cz", idx), cz, t.cz);
        check($sformatf("v%0d_ready_low_in_walk", idx), tri_ready, 0);

        ex = t.xmin; ey = t.ymin; npix = 0;
        order_ok = 1'b1; last_ok = 1'b1; fin = 1'b0; guard = 0;
        while (!fin && guard < 20000) begin
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready = rdy;
            if (!pix_valid || int'(x) != ex || int'(y) != ey) order_ok = 1'b0;
            if (pix_last != ((ex == t.xmax) && (ey == t.ymax))) last_ok = 1'b0;
            if (rdy && pix_valid) begin
                npix++;
                if (ex == t.xmax && ey == t.ymax) fin = 1'b1;
                else if (ex == t.xmax) begin ex = t.xmin; ey++; end
                else ex++;
            end
            @(negedge clk);
            guard++;
            if (abort_after > 0 && npix == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_reset_state", 0, 0 + int'(|{ax, ay, az, bz, cz, abx, acx,
                      aby, acy, x, y, pix_valid, pix_last, tri_done, tri_drop}));
                check("abort_tri_ready", tri_ready, 1);
                @(negedge clk);
                rst_n = 1'b1;
                pix_ready = 1'b1;
                return;
            end
        end
        pix_ready = 1'b1;

        check($sformatf("v%0d_pixel_count", idx), npix, t.npix);
        check($sformatf("v%0d_pixel_order", idx), order_ok, 1);
        check($sformatf("v%0d_pix_last", idx), last_ok, 1);
        check($sformatf("v%0d_tri_done", idx), tri_done, 1);
        check($sformatf("v%0d_valid_drop_after_last", idx), pix_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), tri_done, 0);
        check($sformatf("v%0d_ready_after_done", idx), tri_ready, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //            v0           v1           v2        drop  ax  ay abx aby acx acy  az bz cz  xmin ymin xmax ymax npix
        vecs[0] = '{10, 5, 11,  20, 15, 22,   5, 12, 33,  0,   10,  5, 10, 10, -5,  7, 11, 22, 33,   5,   5,  20,  15, 176};
        vecs[1] = '{20, 15, 22,  5, 12, 33,  10,  5, 11,  0,   10,  5, 10, 10, -5,  7, 11, 22, 33,   5,   5,  20,  15, 176};
        vecs[2] = '{ 5, 5, 1,   10,  5, 2,    0,  9, 3,   0,    5,  5,  5,  0, -5,  4,  1,  2,  3,   0,   5,  10,   9,  55};
        vecs[3] = '{ 0, 0, 0,  200, 10, 0,    0, 20, 0,   1,    0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   0,   0,   0,   0};
        vecs[4] = '{300, 100, 40, 380, 120, 50, 310, 127, 60, 0, 300, 100, 80, 20, 10, 27, 40, 50, 60, 300, 100, 319, 127, 560};
        vecs[5] = '{330, 0, 1,  340,  5, 2,  335,  9, 3,   1,    0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   0,   0,   0,   0};
        vecs[6] = '{ 0, 0, 0,   10, 10, 0,   20, 20, 0,  COLLINEAR_DROP,
                                                               0,  0, 10, 10, 20, 20,  0,  0,  0,   0,   0,  20,  20, 441};

        rst_n = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        v0x = '0; v1x = '0; v2x = '0;
        v0y = '0; v1y = '0; v2y = '0;
        v0z = '0; v1z = '0; v2z = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_tri(i, 1'b0, 0);
        end

        // Backpressure on the basic triangle and on the clipped one.
        run_tri(0, 1'b1, 0);
        run_tri(4, 1'b1, 0);

        // Reset mid-walk, then the pipe must accept a fresh triangle.
        run_tri(0, 1'b0, 10);
        check_reset_state("after_abort");
        run_tri(2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
